// File: rtl/prog_ram_arbiter_if.sv
// Bus bundle between the CPU fetch port, the program loader, the arbiter and the RAM array.
// The slave modport is the arbiter's view; master is the surrounding system (requesters + RAM).
interface prog_ram_arbiter_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
);
  logic              cpu_req;
  logic [ADDR_W-1:0] cpu_addr;
  logic              cpu_ack;
  logic [DATA_W-1:0] cpu_rdata;

  logic              ldr_req;
  logic              ldr_we;
  logic [ADDR_W-1:0] ldr_addr;
  logic [DATA_W-1:0] ldr_wdata;
  logic              ldr_ack;
  logic [DATA_W-1:0] ldr_rdata;

  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  logic [1:0]        owner;
  logic              busy;

  modport slave (
    input  cpu_req, cpu_addr, ldr_req, ldr_we, ldr_addr, ldr_wdata, ram_rdata,
    output cpu_ack, cpu_rdata, ldr_ack, ldr_rdata,
    output ram_en, ram_we, ram_addr, ram_wdata, owner, busy
  );

  modport master (
    output cpu_req, cpu_addr, ldr_req, ldr_we, ldr_addr, ldr_wdata, ram_rdata,
    input  cpu_ack, cpu_rdata, ldr_ack, ldr_rdata,
    input  ram_en, ram_we, ram_addr, ram_wdata, owner, busy
  );
endinterface

// File: rtl/prog_ram_arbiter.sv
// Shares the program/data RAM between the CPU (reads) and the loader (reads/writes).
// Loader has priority, but only MAX_BURST consecutive loader grants while the CPU waits.
module prog_ram_arbiter #(
  parameter int ADDR_W    = 4,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              reset,
  prog_ram_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;

  localparam logic [1:0] OWN_NONE  = 2'b00;
  localparam logic [1:0] OWN_CPU   = 2'b01;
  localparam logic [1:0] OWN_LDR   = 2'b10;
  localparam logic [3:0] BURST_LIM = 4'(MAX_BURST);

  state_t            state_q;
  logic [1:0]        owner_q;
  logic              busy_q;
  logic              is_wr_q;
  logic              ram_en_q;
  logic              ram_we_q;
  logic [ADDR_W-1:0] ram_addr_q;
  logic [DATA_W-1:0] ram_wdata_q;
  logic              cpu_ack_q;
  logic              ldr_ack_q;
  logic [DATA_W-1:0] cpu_rdata_q;
  logic [DATA_W-1:0] ldr_rdata_q;
  logic [3:0]        burst_cnt_q;
  logic [3:0]        burst_cnt_d;
  logic              grant_ldr_d;
  logic              grant_cpu_d;
  logic              resp_cpu;
  logic              resp_ldr_rd;

  always_comb begin
    grant_ldr_d = bus.ldr_req && !(bus.cpu_req && (burst_cnt_q == BURST_LIM));
    grant_cpu_d = bus.cpu_req && !grant_ldr_d;
    burst_cnt_d = burst_cnt_q;
    if (!bus.cpu_req || grant_cpu_d) begin
      burst_cnt_d = 4'd0;
    end else if (grant_ldr_d && (burst_cnt_q < BURST_LIM)) begin
      burst_cnt_d = burst_cnt_q + 4'd1;
    end
  end

  // RAM data arrives during RESP, so the requester sees it straight through in its ack cycle.
  assign resp_cpu    = (state_q == RESP) && (owner_q == OWN_CPU);
  assign resp_ldr_rd = (state_q == RESP) && (owner_q == OWN_LDR) && !is_wr_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      owner_q     <= OWN_NONE;
      busy_q      <= 1'b0;
      is_wr_q     <= 1'b0;
      ram_en_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      cpu_ack_q   <= 1'b0;
      ldr_ack_q   <= 1'b0;
      cpu_rdata_q <= '0;
      ldr_rdata_q <= '0;
      burst_cnt_q <= 4'd0;
    end else begin
      case (state_q)
        IDLE: begin
          burst_cnt_q <= burst_cnt_d;
          if (grant_ldr_d) begin
            state_q     <= ACCESS;
            owner_q     <= OWN_LDR;
            busy_q      <= 1'b1;
            is_wr_q     <= bus.ldr_we;
            ram_en_q    <= 1'b1;
            ram_we_q    <= bus.ldr_we;
            ram_addr_q  <= bus.ldr_addr;
            ram_wdata_q <= bus.ldr_we ? bus.ldr_wdata : '0;
          end else if (grant_cpu_d) begin
            state_q     <= ACCESS;
            owner_q     <= OWN_CPU;
            busy_q      <= 1'b1;
            is_wr_q     <= 1'b0;
            ram_en_q    <= 1'b1;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= bus.cpu_addr;
            ram_wdata_q <= '0;
          end
        end
        ACCESS: begin
          state_q     <= RESP;
          ram_en_q    <= 1'b0;
          ram_we_q    <= 1'b0;
          ram_addr_q  <= '0;
          ram_wdata_q <= '0;
          cpu_ack_q   <= (owner_q == OWN_CPU);
          ldr_ack_q   <= (owner_q == OWN_LDR);
        end
        RESP: begin
          state_q   <= IDLE;
          owner_q   <= OWN_NONE;
          busy_q    <= 1'b0;
          is_wr_q   <= 1'b0;
          cpu_ack_q <= 1'b0;
          ldr_ack_q <= 1'b0;
          if (resp_cpu) begin
            cpu_rdata_q <= bus.ram_rdata;
          end
          if (resp_ldr_rd) begin
            ldr_rdata_q <= bus.ram_rdata;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.cpu_ack   = cpu_ack_q;
  assign bus.ldr_ack   = ldr_ack_q;
  assign bus.cpu_rdata = resp_cpu ? bus.ram_rdata : cpu_rdata_q;
  assign bus.ldr_rdata = resp_ldr_rd ? bus.ram_rdata : ldr_rdata_q;
  assign bus.ram_en    = ram_en_q;
  assign bus.ram_we    = ram_we_q;
  assign bus.ram_addr  = ram_addr_q;
  assign bus.ram_wdata = ram_wdata_q;
  assign bus.owner     = owner_q;
  assign bus.busy      = busy_q;
endmodule

// File: tb/tb_prog_ram_arbiter.sv
// Bench for prog_ram_arbiter: a registered-read RAM model, a table of single transactions,
// and hand-written sequences for contention, burst limit, reset abort and early request drop.
`timescale 1ns/1ps
module tb_prog_ram_arbiter;
  localparam int AW = 4;
  localparam int DW = 8;
  localparam int MB = 4;

  typedef struct {
    logic          is_ldr;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] exp_rdata;
  } vec_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  prog_ram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
  prog_ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  logic [DW-1:0] mem [0:15];
  logic [DW-1:0] ram_q = '0;
  logic          pre_we = 1'b0;
  logic [AW-1:0] pre_addr = '0;
  logic [DW-1:0] pre_data = '0;

  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (bus.ram_en && bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
    if (bus.ram_en) ram_q <= mem[bus.ram_addr];
  end
  assign bus.ram_rdata = ram_q;

  int total = 0;
  int bad   = 0;
  logic [DW-1:0] exp_cpu_hold = '0;
  logic [DW-1:0] exp_ldr_hold = '0;
  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int lat;
    if (v.is_ldr) begin
      bus.ldr_req = 1'b1; bus.ldr_we = v.we; bus.ldr_addr = v.addr; bus.ldr_wdata = v.wdata;
    end else begin
      bus.cpu_req = 1'b1; bus.cpu_addr = v.addr;
    end
    tick();
    check("access_en", bus.ram_en, 1);
    check("access_addr", bus.ram_addr, v.addr);
    check("access_we", bus.ram_we, v.is_ldr & v.we);
    check("access_owner", bus.owner, v.is_ldr ? 2'b10 : 2'b01);
    check("access_busy", bus.busy, 1);
    if (v.is_ldr && v.we) check("access_wdata", bus.ram_wdata, v.wdata);
    lat = 1;
    while (!(v.is_ldr ? bus.ldr_ack : bus.cpu_ack) && lat < 8) begin
      tick();
      lat++;
    end
    check("ack_latency", lat, 2);
    check("resp_en", bus.ram_en, 0);
    check("resp_we", bus.ram_we, 0);
    if (v.is_ldr) begin
      if (!v.we) exp_ldr_hold = v.exp_rdata;
      check("ldr_rdata", bus.ldr_rdata, exp_ldr_hold);
      check("cpu_rdata_held", bus.cpu_rdata, exp_cpu_hold);
    end else begin
      exp_cpu_hold = v.exp_rdata;
      check("cpu_rdata", bus.cpu_rdata, exp_cpu_hold);
      check("ldr_rdata_held", bus.ldr_rdata, exp_ldr_hold);
    end
    bus.ldr_req = 1'b0;
    bus.cpu_req = 1'b0;
    tick();
    check("idle_acks", {bus.cpu_ack, bus.ldr_ack}, 0);
    check("idle_owner", bus.owner, 0);
    check("idle_busy", bus.busy, 0);
    check("idle_addr", bus.ram_addr, 0);
    $display("txn %0d: %s %s addr=%0d wdata=%02h latency=%0d", idx, v.is_ldr ? "LDR" : "CPU",
             v.we ? "WR" : "RD", v.addr, v.wdata, lat);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "simulation timeout");
  end

  initial begin
    int la, ca, n, since_c, acks, en_cnt, got, ack_c;
    int exp_seq [10];
    exp_seq = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};

    vecs[0] = '{1'b1, 1'b1, 4'd3,  8'h10, 8'h00};
    vecs[1] = '{1'b0, 1'b0, 4'd3,  8'h00, 8'h10};
    vecs[2] = '{1'b1, 1'b1, 4'd15, 8'hFF, 8'h00};
    vecs[3] = '{1'b1, 1'b0, 4'd15, 8'h00, 8'hFF};
    vecs[4] = '{1'b1, 1'b1, 4'd0,  8'h5A, 8'h00};
    vecs[5] = '{1'b0, 1'b0, 4'd0,  8'h00, 8'h5A};
    vecs[6] = '{1'b0, 1'b0, 4'd9,  8'h00, 8'h0A};
    vecs[7] = '{1'b1, 1'b0, 4'd9,  8'h00, 8'h0A};

    bus.cpu_req = 1'b0; bus.cpu_addr = '0;
    bus.ldr_req = 1'b0; bus.ldr_we = 1'b0; bus.ldr_addr = '0; bus.ldr_wdata = '0;

    // Reset state, with the preload of RAM[9] done while reset is held.
    pre_we = 1'b1; pre_addr = 4'd9; pre_data = 8'h0A;
    tick();
    pre_we = 1'b0;
    tick();
    check("rst_outputs", {bus.cpu_ack, bus.ldr_ack, bus.ram_en, bus.ram_we, bus.busy}, 0);
    check("rst_owner", bus.owner, 0);
    check("rst_bus", {bus.ram_addr, bus.ram_wdata, bus.cpu_rdata, bus.ldr_rdata}, 0);
    reset = 1'b0;
    tick();
    check("post_rst_busy", bus.busy, 0);

    // Single-requester transactions; vecs[6] is the CPU read of the preloaded word.
    run_vec(vecs[6], 6);
    for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

    // Both request together: loader first, CPU acked three cycles later.
    bus.ldr_req = 1'b1; bus.ldr_we = 1'b0; bus.ldr_addr = 4'd15;
    bus.cpu_req = 1'b1; bus.cpu_addr = 4'd9;
    la = 0; ca = 0;
    for (int c = 1; c <= 12 && (la == 0 || ca == 0); c++) begin
      tick();
      if (bus.ldr_ack) begin la = c; check("both_ldr_rdata", bus.ldr_rdata, 8'hFF); bus.ldr_req = 1'b0; end
      if (bus.cpu_ack) begin ca = c; check("both_cpu_rdata", bus.cpu_rdata, 8'h0A); bus.cpu_req = 1'b0; end
    end
    check("both_ldr_ack_cycle", la, 2);
    check("both_cpu_ack_cycle", ca, 5);
    $display("txn both: ldr ack at %0d, cpu ack at %0d", la, ca);
    tick();

    // Both held continuously: burst limit must let the CPU in every fifth grant.
    bus.ldr_req = 1'b1; bus.ldr_we = 1'b0; bus.ldr_addr = 4'd3;
    bus.cpu_req = 1'b1; bus.cpu_addr = 4'd0;
    n = 0; since_c = 0;
    for (int c = 1; c <= 40 && n < 10; c++) begin
      tick();
      if (bus.ldr_ack || bus.cpu_ack) begin
        got = bus.ldr_ack ? 1 : 0;
        check($sformatf("burst_grant%0d", n), got, exp_seq[n]);
        check("burst_single_ack", {bus.ldr_ack, bus.cpu_ack} == 2'b11, 0);
        if (bus.cpu_ack) begin
          check("burst_cpu_rdata", bus.cpu_rdata, 8'h5A);
          check("burst_cpu_wait_le15", (c - since_c) <= 15, 1);
          since_c = c;
        end else begin
          check("burst_ldr_rdata", bus.ldr_rdata, 8'h10);
        end
        $display("txn burst %0d: %s ack at cycle %0d", n, got == 1 ? "LDR" : "CPU", c);
        n++;
      end
    end
    check("burst_grant_count", n, 10);
    bus.ldr_req = 1'b0; bus.cpu_req = 1'b0;
    tick();
    tick();

    // Reset during the ACCESS cycle of a loader write aborts it.
    bus.ldr_req = 1'b1; bus.ldr_we = 1'b1; bus.ldr_addr = 4'd7; bus.ldr_wdata = 8'h77;
    tick();
    check("abort_access_en", {bus.ram_en, bus.ram_we}, 2'b11);
    reset = 1'b1;
    bus.ldr_req = 1'b0;
    tick();
    check("abort_en_we", {bus.ram_en, bus.ram_we}, 0);
    check("abort_busy_owner", {bus.busy, bus.owner}, 0);
    check("abort_ack", {bus.ldr_ack, bus.cpu_ack}, 0);
    check("abort_rdata_cleared", {bus.cpu_rdata, bus.ldr_rdata}, 0);
    reset = 1'b0;
    acks = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (bus.ldr_ack || bus.cpu_ack || bus.ram_en) acks++;
    end
    check("abort_no_activity", acks, 0);
    $display("txn abort: reset during loader write access");

    // CPU request held for one cycle only still completes exactly once.
    bus.cpu_req = 1'b1; bus.cpu_addr = 4'd9;
    en_cnt = 0; ack_c = 0;
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (c == 1) bus.cpu_req = 1'b0;
      if (bus.ram_en) en_cnt++;
      if (bus.cpu_ack) begin
        ack_c = c;
        check("drop_cpu_rdata", bus.cpu_rdata, 8'h0A);
      end
    end
    check("drop_ack_cycle", ack_c, 2);
    check("drop_single_access", en_cnt, 1);
    $display("txn drop: cpu ack at %0d, accesses=%0d", ack_c, en_cnt);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
